// File: rtl/sll_multicycle_pkg.sv
// Shared types and constants for the iterative logical-left shifter.
package sll_multicycle_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift distance handled by binary stage k.
  function automatic int stage_dist(input int k);
    return 32'sd1 << k;
  endfunction

endpackage

// File: rtl/sll_multicycle_stage.sv
// sll_stage: combinational conditional left shift by 2^K, zero-filled from the LSB.
module sll_stage
  import sll_multicycle_pkg::*;
#(
  parameter int K     = 0,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] shifted
);

  localparam int DIST = stage_dist(K);

  assign shifted = en ? (data << DIST) : data;

endmodule

// File: rtl/sll_multicycle.sv
// Iterative logical-left shifter resolving one binary stage of shamt per cycle.
// Optional macro SLL_EARLY_EXIT_EN: finish as soon as no remaining shamt bits are set.
module sll_multicycle
  import sll_multicycle_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int STG_W = $clog2(SHAMT_W);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SHAMT_W - 1);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] amt;
  logic [STG_W-1:0]   stage;
  logic               last;
  logic [WIDTH-1:0]   chain [0:SHAMT_W];
  logic [WIDTH-1:0]   shifted_acc;

  // Only the stage matching the counter is enabled, so the chain applies one shift per cycle.
  assign chain[0] = acc;
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    sll_stage #(
      .K     (k),
      .WIDTH (WIDTH)
    ) u_stage (
      .en      (amt[k] && (stage == STG_W'(k))),
      .data    (chain[k]),
      .shifted (chain[k+1])
    );
  end
  assign shifted_acc = chain[SHAMT_W];

`ifdef SLL_EARLY_EXIT_EN
  logic [SHAMT_W-1:0] low_mask;

  // Mask of amt bits at or below the current stage.
  always_comb begin
    low_mask = '0;
    for (int i = 0; i < SHAMT_W; i++) begin
      low_mask[i] = (i <= int'(stage));
    end
  end

  assign last = (stage == '0) || ((amt & low_mask) == '0);
`else
  assign last = (stage == '0);
`endif

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? SHIFT : IDLE;
      SHIFT:   next_state = last ? DONE : SHIFT;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      amt    <= '0;
      stage  <= LAST_STAGE;
    end else begin
      state <= next_state;
      busy  <= (next_state == SHIFT);
      done  <= (next_state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= data_in;
            amt   <= shamt;
            stage <= LAST_STAGE;
          end
        end
        SHIFT: begin
          acc <= shifted_acc;
          if (stage != '0) stage <= stage - 1'b1;
          if (last) result <= shifted_acc;
        end
        default: begin
          stage <= LAST_STAGE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sll_multicycle.sv
// Scoreboard bench for sll_multicycle; latencies follow SLL_EARLY_EXIT_EN when defined.
module tb_sll_multicycle;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q [$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   last_acc;

  sll_multicycle dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive start for one edge from the current (negedge) time; caller aligns.
  task automatic drive(input logic [31:0] d, input logic [4:0] s);
    start   = 1'b1;
    data_in = d;
    shamt   = s;
    @(posedge clock);
    #1;
    last_acc = cyc;
    start    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [31:0] res,
                       input int lat_fixed, input int lat_early);
    exp_t e;
    drive(d, s);
    e.res = res;
`ifdef SLL_EARLY_EXIT_EN
    e.cyc = last_acc + lat_early;
`else
    e.cyc = last_acc + lat_fixed;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: %0d results still outstanding", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int dcount;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = 32'h0;
    shamt   = 5'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    reset = 1'b0;

    dcount = 0;
    repeat (10) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("idle_no_done", 32'(dcount), 32'd0);

    // Directed single operations.
    @(negedge clock); issue(32'h0000_0001, 5'd5,  32'h0000_0020, 5, 5); drain();
    @(negedge clock); issue(32'h8000_0001, 5'd31, 32'h8000_0000, 5, 5); drain();
    @(negedge clock); issue(32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00, 5, 3); drain();
    @(negedge clock); issue(32'h1234_5678, 5'd0,  32'h1234_5678, 5, 1); drain();
    @(negedge clock); issue(32'h0000_ABCD, 5'd16, 32'hABCD_0000, 5, 2); drain();
    @(negedge clock); issue(32'hA5A5_A5A5, 5'd2,  32'h9696_9694, 5, 5); drain();
    repeat (3) @(negedge clock);
    check("result_hold_idle", result, 32'h9696_9694);

    // Starts while busy are ignored; old result holds mid-operation.
    @(negedge clock); issue(32'h0000_000F, 5'd1, 32'h0000_001E, 5, 5);
    @(negedge clock);
    check("busy_mid_op", 32'(busy), 32'd1);
    start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd3;
    @(negedge clock);
    data_in = 32'h0F0F_0F0F; shamt = 5'd7;
    @(negedge clock);
    start = 1'b0;
    check("result_hold_busy", result, 32'h9696_9694);
    drain();

    // Back-to-back: second start presented during the DONE cycle.
    @(negedge clock); issue(32'h0000_0001, 5'd5, 32'h0000_0020, 5, 5);
    begin
      int target;
      int n;
`ifdef SLL_EARLY_EXIT_EN
      target = last_acc + 5;
`else
      target = last_acc + 5;
`endif
      n = 0;
      while (cyc != target && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("b2b_done_seen", 32'(done), 32'd1);
      issue(32'hDEAD_BEEF, 5'd8, 32'hADBE_EF00, 5, 3);
    end
    drain();

    // Reset mid-operation aborts with no done pulse.
    @(negedge clock); drive(32'hFFFF_FFFF, 5'd4);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    dcount = 0;
    repeat (6) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    issue(32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 5, 4); drain();

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; data_in = 32'h1; shamt = 5'd1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("reset_wins_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
